// File: rtl/bwd_layer_seq.sv
// bwd_layer_seq: buffers NUM_OUT incoming deltas, then computes the propagated
// deltas p[i] = sum_j W[j][i] * d[j] with one shared fixed-point MAC and streams
// NUM_IN results downstream. The sum of squared deltas is folded into the
// running error chain (ERR_ACC_IN -> ERR_ACC_OUT).
// Optional build macro: BWD_LAYER_SAT_EN -- saturate PROP_OUT / ERR_ACC_OUT to
// the DATA_W range instead of wrapping to the low DATA_W bits.
// The weight ROM image is supplied through the WEIGHTS parameter (word
// j*NUM_IN+i holds W[j][i]), so the block elaborates without an image file.
module bwd_layer_seq #(
    parameter int NUM_IN    = 2,
    parameter int NUM_OUT   = 2,
    parameter int DATA_W    = 32,
    parameter int FRAC_W    = 16,
    parameter int ACC_GUARD = 8,
    parameter logic [NUM_OUT*NUM_IN*DATA_W-1:0] WEIGHTS =
        {32'hFFFF_0000, 32'h0000_8000, 32'h0002_0000, 32'h0001_0000}
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [DATA_W-1:0] delta_in_i,
    input  logic              delta_valid_i,
    output logic              delta_ready_o,
    input  logic [DATA_W-1:0] err_acc_in_i,
    output logic [DATA_W-1:0] err_acc_out_o,
    output logic [DATA_W-1:0] prop_out_o,
    output logic              prop_valid_o,
    input  logic              prop_ready_i,
    output logic              prop_last_o,
    output logic              busy_o,
    output logic              done_o
);
    localparam int ACC_W  = DATA_W + ACC_GUARD;
    localparam int PROD_W = 2 * DATA_W;
    localparam int JW     = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1;
    localparam int IW     = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;
    localparam int CW     = $clog2(NUM_OUT + 1);
    localparam int ROM_N  = NUM_OUT * NUM_IN;
    localparam int AW     = (ROM_N > 1) ? $clog2(ROM_N) : 1;

`ifdef BWD_LAYER_SAT_EN
    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'({1'b0, {(DATA_W-1){1'b1}}});
    localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;
`endif

    typedef enum logic [1:0] {IDLE, LOAD, MAC, EMIT} state_t;

    state_t                   state_q, state_d;
    logic [JW-1:0]            j_q, j_d;
    logic [IW-1:0]            i_q, i_d;
    logic [CW-1:0]            k_q, k_d;      // MAC step: 0 = clear, 1..NUM_OUT = products
    logic signed [DATA_W-1:0] dbuf_q [NUM_OUT];
    logic signed [DATA_W-1:0] dbuf_d [NUM_OUT];
    logic signed [ACC_W-1:0]  acc_q, acc_d;
    logic signed [ACC_W-1:0]  err_q, err_d;
    logic [DATA_W-1:0]        prop_q, prop_d;
    logic [DATA_W-1:0]        err_out_q, err_out_d;
    logic                     done_q, done_d;

    logic [DATA_W-1:0]        rom [ROM_N];
    logic [DATA_W-1:0]        rom_q;
    logic [AW-1:0]            rom_addr;
    logic [JW-1:0]            mac_j;
    logic signed [ACC_W-1:0]  err_in_ext;

    // Fixed-point product: full 2*DATA_W result, arithmetic shift (floor), kept to ACC_W.
    function automatic logic signed [ACC_W-1:0] scaled_prod(
        input logic signed [DATA_W-1:0] a,
        input logic signed [DATA_W-1:0] b
    );
        logic signed [PROD_W-1:0] p;
        p = PROD_W'(a) * PROD_W'(b);
        p = p >>> FRAC_W;
        return p[ACC_W-1:0];
    endfunction

    // Reduce an accumulator to an output word: saturate or wrap.
    function automatic logic [DATA_W-1:0] clamp(input logic signed [ACC_W-1:0] v);
`ifdef BWD_LAYER_SAT_EN
        if (v > SAT_MAX) return SAT_MAX[DATA_W-1:0];
        if (v < SAT_MIN) return SAT_MIN[DATA_W-1:0];
`endif
        return v[DATA_W-1:0];
    endfunction

    for (genvar gi = 0; gi < ROM_N; gi++) begin : g_rom
        assign rom[gi] = WEIGHTS[gi*DATA_W +: DATA_W];
    end

    assign rom_addr   = AW'(int'(k_q) * NUM_IN + int'(i_q));
    assign mac_j      = JW'(k_q - 1'b1);
    assign err_in_ext = ACC_W'(signed'(err_acc_in_i));

    // Registered weight read: the address issued in MAC step k is consumed in step k+1.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rom_q <= '0;
        end else if (state_q == MAC && k_q < CW'(NUM_OUT)) begin
            rom_q <= rom[rom_addr];
        end
    end

    // State, counters, delta buffer and accumulators.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            j_q       <= '0;
            i_q       <= '0;
            k_q       <= '0;
            acc_q     <= '0;
            err_q     <= '0;
            prop_q    <= '0;
            err_out_q <= '0;
            done_q    <= 1'b0;
            for (int n = 0; n < NUM_OUT; n++) dbuf_q[n] <= '0;
        end else begin
            state_q   <= state_d;
            j_q       <= j_d;
            i_q       <= i_d;
            k_q       <= k_d;
            acc_q     <= acc_d;
            err_q     <= err_d;
            prop_q    <= prop_d;
            err_out_q <= err_out_d;
            done_q    <= done_d;
            dbuf_q    <= dbuf_d;
        end
    end

    // Next-state and datapath updates for the load / MAC / emit sequence.
    always_comb begin
        state_d   = state_q;
        j_d       = j_q;
        i_d       = i_q;
        k_d       = k_q;
        dbuf_d    = dbuf_q;
        acc_d     = acc_q;
        err_d     = err_q;
        prop_d    = prop_q;
        err_out_d = err_out_q;
        done_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (delta_valid_i) begin
                    dbuf_d[0] = delta_in_i;
                    err_d     = err_in_ext + scaled_prod(delta_in_i, delta_in_i);
                    if (NUM_OUT == 1) begin
                        state_d = MAC;
                        k_d     = '0;
                        i_d     = '0;
                    end else begin
                        j_d     = JW'(1);
                        state_d = LOAD;
                    end
                end
            end
            LOAD: begin
                if (delta_valid_i) begin
                    dbuf_d[j_q] = delta_in_i;
                    err_d       = err_q + scaled_prod(delta_in_i, delta_in_i);
                    if (j_q == JW'(NUM_OUT - 1)) begin
                        state_d = MAC;
                        j_d     = '0;
                        k_d     = '0;
                        i_d     = '0;
                    end else begin
                        j_d = j_q + 1'b1;
                    end
                end
            end
            MAC: begin
                if (k_q == '0) begin
                    acc_d = '0;
                end else begin
                    acc_d = acc_q + scaled_prod(rom_q, dbuf_q[mac_j]);
                end
                if (k_q == CW'(NUM_OUT)) begin
                    state_d = EMIT;
                    prop_d  = clamp(acc_d);
                end else begin
                    k_d = k_q + 1'b1;
                end
            end
            EMIT: begin
                if (prop_ready_i) begin
                    k_d = '0;
                    if (i_q == IW'(NUM_IN - 1)) begin
                        state_d   = IDLE;
                        i_d       = '0;
                        err_out_d = clamp(err_q);
                        done_d    = 1'b1;
                    end else begin
                        i_d     = i_q + 1'b1;
                        state_d = MAC;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign delta_ready_o = (state_q == IDLE || state_q == LOAD) && !rst_i;
    assign prop_valid_o  = (state_q == EMIT);
    assign prop_last_o   = (state_q == EMIT) && (i_q == IW'(NUM_IN - 1));
    assign prop_out_o    = prop_q;
    assign err_acc_out_o = err_out_q;
    assign busy_o        = (state_q != IDLE);
    assign done_o        = done_q;

endmodule

// File: tb/tb_bwd_layer_seq.sv
`timescale 1ns/1ps
// Scoreboard bench for bwd_layer_seq: stimulus pushes expected results computed
// from the matrix/vector definition; a negedge monitor pops and compares.
module tb_bwd_layer_seq;
    localparam int NUM_IN  = 2;
    localparam int NUM_OUT = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] delta_in = '0;
    logic        delta_valid = 1'b0;
    logic        delta_ready;
    logic [31:0] err_in = '0;
    logic [31:0] err_out;
    logic [31:0] prop_out;
    logic        prop_valid;
    logic        prop_ready = 1'b0;
    logic        prop_last;
    logic        busy;
    logic        done;

    always #5 clk = ~clk;

    bwd_layer_seq #(
        .NUM_IN(NUM_IN), .NUM_OUT(NUM_OUT), .DATA_W(32), .FRAC_W(16), .ACC_GUARD(8),
        .WEIGHTS({32'hFFFF_0000, 32'h0000_8000, 32'h0002_0000, 32'h0001_0000})
    ) dut (
        .clk_i(clk), .rst_i(rst),
        .delta_in_i(delta_in), .delta_valid_i(delta_valid), .delta_ready_o(delta_ready),
        .err_acc_in_i(err_in), .err_acc_out_o(err_out),
        .prop_out_o(prop_out), .prop_valid_o(prop_valid), .prop_ready_i(prop_ready),
        .prop_last_o(prop_last), .busy_o(busy), .done_o(done)
    );

    typedef struct {
        logic [31:0] val;
        logic        last;
    } prop_exp_t;

    int          checks = 0;
    int          errors = 0;
    longint      cyc = 0;
    prop_exp_t   prop_q[$];
    logic [31:0] err_q[$];
    int          ready_mode = 0;   // 0 always ready, 1 random, 2 hold low 10 cycles per output
    int          hold_cnt = 0;
    bit          gap_chk = 1'b0;

    // W[j][i]: weight from forward output j to forward input i
    logic [31:0] W [NUM_OUT][NUM_IN] = '{'{32'h0001_0000, 32'h0002_0000},
                                         '{32'h0000_8000, 32'hFFFF_0000}};

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Sign-extend the low 40 bits (accumulator width DATA_W+ACC_GUARD).
    function automatic longint wrap_acc(input longint x);
        return (x <<< 24) >>> 24;
    endfunction

    // Q16.16 product rounded toward -inf, reduced to accumulator width.
    function automatic longint term(input logic [31:0] a, input logic [31:0] b);
        longint p;
        p = longint'(signed'(a)) * longint'(signed'(b));
        return wrap_acc(p >>> 16);
    endfunction

    function automatic logic [31:0] to_out(input longint a);
        longint maxv;
        longint minv;
        maxv = 64'h7FFF_FFFF;
        minv = -maxv - 1;
`ifdef BWD_LAYER_SAT_EN
        if (a > maxv) return 32'h7FFF_FFFF;
        if (a < minv) return 32'h8000_0000;
`else
        if (a > maxv || a < minv) return a[31:0];
`endif
        return a[31:0];
    endfunction

    task automatic push_expect(input logic [31:0] d0, input logic [31:0] d1, input logic [31:0] e);
        logic [31:0] d [NUM_OUT];
        longint acc;
        d[0] = d0;
        d[1] = d1;
        for (int i = 0; i < NUM_IN; i++) begin
            acc = 0;
            for (int j = 0; j < NUM_OUT; j++) acc = wrap_acc(acc + term(W[j][i], d[j]));
            prop_q.push_back('{val: to_out(acc), last: (i == NUM_IN - 1)});
        end
        acc = wrap_acc(longint'(signed'(e)));
        for (int j = 0; j < NUM_OUT; j++) acc = wrap_acc(acc + term(d[j], d[j]));
        err_q.push_back(to_out(acc));
    endtask

    // ---------------- downstream ready driver ----------------
    always begin
        @(posedge clk);
        #1;
        case (ready_mode)
            0: prop_ready = 1'b1;
            1: prop_ready = ($urandom_range(0, 3) != 0);
            default: begin
                if (!prop_valid) begin
                    hold_cnt   = 0;
                    prop_ready = 1'b0;
                end else if (hold_cnt < 10) begin
                    hold_cnt++;
                    prop_ready = 1'b0;
                end else begin
                    prop_ready = 1'b1;
                end
            end
        endcase
    end

    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- monitor / scoreboard ----------------
    logic [31:0] held_val = '0;
    bit          held = 1'b0;
    logic [31:0] err_prev = '0;
    longint      last_hs = 0;
    bit          prev_nonlast = 1'b0;

    always @(negedge clk) begin : monitor
        prop_exp_t   pe;
        logic [31:0] ee;
        if (!rst) begin
            if (held && prop_valid) check("prop_stable", prop_out, held_val);
            if (prop_valid) check("delta_ready_in_emit", delta_ready, 1'b0);
            if (prop_valid && prop_ready) begin
                if (prop_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL prop_unexpected: got 0x%0h, expected no output", prop_out);
                end else begin
                    pe = prop_q.pop_front();
                    check("prop_out", prop_out, pe.val);
                    check("prop_last", prop_last, pe.last);
                end
                if (gap_chk && prev_nonlast) check("hs_gap", cyc - last_hs, NUM_OUT + 2);
                prev_nonlast = !prop_last;
                last_hs      = cyc;
            end
            held     = prop_valid && !prop_ready;
            held_val = prop_out;
            if (done) begin
                if (err_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL done_unexpected: got err 0x%0h, expected no done", err_out);
                end else begin
                    ee = err_q.pop_front();
                    check("err_acc_out", err_out, ee);
                end
                if (delta_valid) check("no_bubble_ready", delta_ready, 1'b1);
            end else begin
                check("err_hold", err_out, err_prev);
            end
            err_prev = err_out;
        end else begin
            held     = 1'b0;
            err_prev = err_out;
        end
    end

    // ---------------- stimulus ----------------
    task automatic send_delta(input logic [31:0] d, input logic [31:0] e, input bit gaps);
        bit hs;
        int n;
        if (gaps) begin
            delta_valid = 1'b0;
            repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        end
        delta_valid = 1'b1;
        delta_in    = d;
        err_in      = e;
        n  = 0;
        hs = 1'b0;
        while (!hs && n < 500) begin
            @(negedge clk);
            hs = delta_ready;
            @(posedge clk);
            #1;
            n++;
        end
        if (!hs) check("delta_accept_timeout", 1'b0, 1'b1);
    endtask

    task automatic run_pass(input logic [31:0] d0, input logic [31:0] d1, input logic [31:0] e,
                            input bit b2b, input bit chk_lat, input bit gaps, input bit expect_it);
        int n;
        if (expect_it) push_expect(d0, d1, e);
        send_delta(d0, e, gaps);
        send_delta(d1, $urandom, gaps);
        if (!b2b) delta_valid = 1'b0;
        if (chk_lat) begin
            n = 0;
            while (n < 20) begin
                @(negedge clk);
                if (prop_valid) break;
                @(posedge clk);
                n++;
            end
            // last delta at edge T -> PROP_VALID in cycle T+NUM_OUT+2, i.e. NUM_OUT+1 edges later
            check("first_valid_latency", n, NUM_OUT + 1);
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while ((prop_q.size() != 0 || err_q.size() != 0 || busy) && n < 1000) begin
            @(posedge clk);
            n++;
        end
        if (n >= 1000) check("drain_timeout", 1'b0, 1'b1);
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] rnd_word(input bit wide);
        logic [31:0] v;
        if (wide) v = $urandom;
        else v = 32'($urandom_range(0, 2097152)) - 32'd1048576;   // about +/-16.0
        return v;
    endfunction

    initial begin : stim
        int nv;
        bit b2b;
        // reset state
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_delta_ready", delta_ready, 1'b0);
        check("rst_prop_valid", prop_valid, 1'b0);
        check("rst_prop_last", prop_last, 1'b0);
        check("rst_prop_out", prop_out, 32'h0);
        check("rst_err_out", err_out, 32'h0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // basic pass with latency and inter-output spacing
        ready_mode = 0;
        gap_chk    = 1'b1;
        run_pass(32'h0001_0000, 32'h0002_0000, 32'h0, 1'b0, 1'b1, 1'b0, 1'b1);
        wait_drain();
        gap_chk = 1'b0;

        // backpressure: ready held low 10 cycles per output
        ready_mode = 2;
        run_pass(32'h0001_0000, 32'h0002_0000, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
        wait_drain();
        ready_mode = 0;

        // overflow of the output range
        run_pass(32'h7FFF_0000, 32'h7FFF_0000, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
        wait_drain();
        run_pass(32'h8000_0000, 32'h7FFF_0000, 32'h1234_5678, 1'b0, 1'b0, 1'b0, 1'b1);
        wait_drain();

        // reset two cycles into MAC: partial pass must vanish
        run_pass(32'h0001_0000, 32'h0002_0000, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("midrst_prop_valid", prop_valid, 1'b0);
        check("midrst_prop_out", prop_out, 32'h0);
        check("midrst_err_out", err_out, 32'h0);
        check("midrst_busy", busy, 1'b0);
        check("midrst_delta_ready", delta_ready, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        nv = 0;
        repeat (15) begin
            @(negedge clk);
            if (prop_valid) nv++;
        end
        check("no_prop_after_rst", nv, 0);
        @(posedge clk);
        #1;
        run_pass(32'h0001_0000, 32'h0002_0000, 32'h0, 1'b0, 1'b1, 1'b0, 1'b1);
        wait_drain();

        // back-to-back: second pair waits on the bus and is taken in the DONE cycle
        run_pass(32'h0003_0000, 32'hFFFE_8000, 32'h0000_1000, 1'b1, 1'b0, 1'b0, 1'b1);
        run_pass(32'h0000_4000, 32'h0001_0000, 32'h0000_0000, 1'b0, 1'b0, 1'b0, 1'b1);
        wait_drain();

        // randomized passes
        for (int t = 0; t < 40; t++) begin
            ready_mode = $urandom_range(0, 1);
            b2b        = ($urandom_range(0, 2) == 0);
            run_pass(rnd_word($urandom_range(0, 3) == 0), rnd_word($urandom_range(0, 3) == 0),
                     rnd_word($urandom_range(0, 1) == 0), b2b, 1'b0, !b2b, 1'b1);
            if (!b2b) wait_drain();
        end
        delta_valid = 1'b0;
        ready_mode  = 0;
        wait_drain();
        check("prop_queue_empty", prop_q.size(), 0);
        check("err_queue_empty", err_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
